// File: rtl/freq_gen_pkg.sv
// Shared definitions for the programmable square-wave generator.
package freq_gen_pkg;

    // Default system clock, and the frequency word width shared with FreMeasure
    localparam int unsigned CLK_HZ_DEF = 50_000_000;
    localparam int unsigned FW_DEF     = 14;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/freq_gen_seq_div.sv
// Restoring sequential divider: one quotient bit per cycle, MSB first.
// The dividend register doubles as the quotient shift register.
module seq_div #(
    parameter int NW = 9,
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] quot
);
    localparam int CW = $clog2(NW + 1);

    logic [NW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] den_q, den_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [DW:0]   trial;
    logic          qbit;

    // One restoring step plus start/restart handling
    always_comb begin
        trial  = {rem_q, dvd_q[NW-1]};
        qbit   = (trial >= {1'b0, den_q});
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            dvd_d  = num;
            rem_d  = '0;
            den_d  = den;
            cnt_d  = CW'(NW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            dvd_d = {dvd_q[NW-2:0], qbit};
            // A failed trial is below den, so it always fits the remainder width
            rem_d = qbit ? DW'(trial - {1'b0, den_q}) : trial[DW-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Control registers (step counter, busy flag)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Datapath registers (dividend/quotient, remainder, divisor)
    always_ff @(posedge clk) begin
        dvd_q <= dvd_d;
        rem_q <= rem_d;
        den_q <= den_d;
    end

    // Final quotient is presented during the last busy cycle
    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(1));
    assign quot = {dvd_q[NW-2:0], qbit};

endmodule

// File: rtl/freq_gen.sv
// Programmable 50% duty square-wave source. Half-period = floor((CLK_HZ/2)/Fre_set),
// clamped to 1. New periods take effect only at a level boundary, so no runt pulses.
module freq_gen
    import freq_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned FW     = FW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [FW-1:0] Fre_set,
    input  logic          load,
    output logic          Sig_out,
    output logic          busy,
    output logic          active,
    output logic          clipped
);
    localparam int            QW       = $clog2(CLK_HZ / 2 + 1);
    localparam logic [QW-1:0] DIVIDEND = QW'(CLK_HZ / 2);

    state_e        state_q, state_d;
    logic [QW-1:0] half_q, half_d;
    logic [QW-1:0] pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [QW-1:0] cnt_q, cnt_d;
    logic          sig_q, sig_d;
    logic          active_q, active_d;
    logic          clip_q, clip_d;

    logic          div_start, div_busy, div_done;
    logic [QW-1:0] div_quot;
    logic [QW-1:0] half_new;
    logic          clip_new;
    logic          res_vld;
    logic          boundary;

    assign div_start = load && (Fre_set != '0);

    seq_div #(
        .NW(QW),
        .DW(FW)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .start(div_start),
        .num  (DIVIDEND),
        .den  (Fre_set),
        .busy (div_busy),
        .done (div_done),
        .quot (div_quot)
    );

    // Results from an aborted divide (state left DIV) are ignored
    assign res_vld  = div_done && (state_q == ST_DIV);
    assign clip_new = (div_quot == '0);
    assign half_new = clip_new ? QW'(1) : div_quot;
    assign boundary = active_q && (cnt_q == half_q - QW'(1));

    // Controller next state, wave counter and half/pending bookkeeping
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        sig_d      = sig_q;
        active_d   = active_q;
        clip_d     = clip_q;

        if (active_q) begin
            if (boundary) begin
                sig_d = ~sig_q;
                cnt_d = '0;
                if (pend_vld_q) begin
                    half_d     = pend_q;
                    pend_vld_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + QW'(1);
            end
        end

        if (load) begin
            // A new request wins: any queued half is dropped, the old half keeps running
            half_d     = half_q;
            pend_vld_d = 1'b0;
            if (Fre_set == '0) begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
                sig_d    = 1'b0;
                cnt_d    = '0;
                clip_d   = 1'b0;
                half_d   = '0;
            end else begin
                state_d = ST_DIV;
            end
        end else if (res_vld) begin
            state_d = ST_RUN;
            clip_d  = clip_new;
            if (active_q) begin
                pend_d     = half_new;
                pend_vld_d = 1'b1;
            end else begin
                half_d   = half_new;
                active_d = 1'b1;
                sig_d    = 1'b1;
                cnt_d    = '0;
            end
        end
    end

    // State and wave registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            half_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            sig_q      <= 1'b0;
            active_q   <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            sig_q      <= sig_d;
            active_q   <= active_d;
            clip_q     <= clip_d;
        end
    end

    assign Sig_out = sig_q;
    assign busy    = div_busy && (state_q == ST_DIV);
    assign active  = active_q;
    assign clipped = clip_q;

endmodule
